// File: rtl/saradc_cdac_ctrl_if.sv
// saradc_cdac_ctrl_if: start/comparator inputs and CDAC switch, status and result outputs
interface saradc_cdac_ctrl_if #(parameter int NBITS = 8);
  logic start;
  logic cmp;
  logic [NBITS:0] cri, crib, crh, crhb, crl, crlb;
  logic busy;
  logic done;
  logic [NBITS-1:0] dout;
  modport master (output start, cmp, input cri, crib, crh, crhb, crl, crlb, busy, done, dout);
  modport slave (input start, cmp, output cri, crib, crh, crhb, crl, crlb, busy, done, dout);
endinterface

// File: rtl/saradc_cdac_ctrl.sv
// saradc_cdac_ctrl: SAR ADC sequencer driving break-before-make CDAC switches, MSB first
module saradc_cdac_ctrl #(
  parameter int NBITS = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic rst,
  saradc_cdac_ctrl_if.slave bus
);
  localparam int NU = NBITS + 1;
  localparam int KW = NBITS > 1 ? $clog2(NBITS) : 1;
  localparam int CMAX = SAMPLE_CYC > SETTLE_CYC ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] T_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [KW-1:0] K_TOP = KW'(NBITS - 1);
  typedef enum logic [2:0] {IDLE, SAMPLE, BRK0, SET, BRK, DONE} state_e;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q;
  logic [NBITS-1:0] res_q, dout_q, bit_k;
  logic [NBITS:0] cri_q, crib_q, crh_q, crhb_q, crl_q, crlb_q;
  logic [NBITS:0] cri_d, crh_d, crl_d, unit_k;
  logic busy_q, done_q, s_end, t_end;
  // Trial pattern for bit k: decided upper bits on H/L, unit k on H, the rest and dummy on L.
  function automatic logic [NBITS:0] set_h(input logic [KW-1:0] k, input logic [NBITS-1:0] r);
    logic [NBITS:0] one;
    one = NU'(1) << k;
    return ({1'b0, r} & ~((one << 1) - NU'(1))) | one;
  endfunction
  assign unit_k = NU'(1) << k_q;
  assign bit_k = NBITS'(1) << k_q;
  assign s_end = cnt_q == S_LAST;
  assign t_end = cnt_q == T_LAST;
  always_comb begin
    cri_d = cri_q;
    crh_d = crh_q;
    crl_d = crl_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        cri_d = '1;
        crh_d = '0;
        crl_d = '0;
      end
      SAMPLE: if (s_end) cri_d = '0;
      BRK0: begin
        crh_d = set_h(K_TOP, res_q);
        crl_d = ~crh_d;
      end
      SET: if (t_end) begin
        crh_d = bus.cmp ? crh_q : crh_q & ~unit_k;
        crl_d = crl_q & ~(unit_k >> 1);
      end
      BRK: begin
        crh_d = k_q != '0 ? set_h(k_q - KW'(1), res_q) : {1'b0, res_q};
        crl_d = ~crh_d;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k_q <= '0;
      res_q <= '0;
      dout_q <= '0;
      cri_q <= '0;
      crh_q <= '0;
      crl_q <= '0;
      crib_q <= '1;
      crhb_q <= '1;
      crlb_q <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cri_q <= cri_d;
      crh_q <= crh_d;
      crl_q <= crl_d;
      crib_q <= ~cri_d;
      crhb_q <= ~crh_d;
      crlb_q <= ~crl_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= bus.start ? SAMPLE : IDLE;
          busy_q <= bus.start;
          cnt_q <= '0;
          res_q <= '0;
        end
        SAMPLE: begin
          state_q <= s_end ? BRK0 : SAMPLE;
          cnt_q <= s_end ? '0 : cnt_q + CW'(1);
        end
        BRK0: begin
          state_q <= SET;
          k_q <= K_TOP;
          cnt_q <= '0;
        end
        SET: begin
          state_q <= t_end ? BRK : SET;
          cnt_q <= t_end ? '0 : cnt_q + CW'(1);
          if (t_end) res_q <= bus.cmp ? res_q | bit_k : res_q & ~bit_k;
        end
        BRK: begin
          state_q <= k_q != '0 ? SET : DONE;
          k_q <= k_q - KW'(1);
          busy_q <= k_q != '0;
          done_q <= k_q == '0;
          if (k_q == '0) dout_q <= res_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cri = cri_q;
  assign bus.crib = crib_q;
  assign bus.crh = crh_q;
  assign bus.crhb = crhb_q;
  assign bus.crl = crl_q;
  assign bus.crlb = crlb_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_saradc_cdac_ctrl.sv
// tb_saradc_cdac_ctrl: timed CMP stimulus per SAR bit, scoreboard monitors check results and switch invariants
module tb_saradc_cdac_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  saradc_cdac_ctrl_if #(.NBITS(8)) if_a ();
  saradc_cdac_ctrl_if #(.NBITS(4)) if_b ();
  saradc_cdac_ctrl #(.NBITS(8), .SAMPLE_CYC(4), .SETTLE_CYC(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  saradc_cdac_ctrl #(.NBITS(4), .SAMPLE_CYC(1), .SETTLE_CYC(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  typedef struct {
    logic [7:0] code;
    int gap;
  } exp_t;
  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  int checks = 0, failures = 0;
  int cyc = 0, last_a = 0, busy_a = 0, busy_b = 0, samp_a = 0, samp_len_a = 0;
  bit dchk_a = 1'b0;
  logic [7:0] dout_a = 8'h00;
  logic [8:0] pa_i = '0, pa_h = '0, pa_l = '0, pb_i = '0, pb_h = '0, pb_l = '0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask
  // Entering track (CRI) straight from the held final code is the only direct closed-to-closed move allowed.
  task automatic inv(input string nm, input logic [8:0] i, ib, h, hb, l, lb, pi, ph, pl);
    chk({nm, "_complement"}, {5'b0, ib, hb, lb}, {5'b0, ~i, ~h, ~l});
    chk({nm, "_onehot"}, {23'b0, (i & h) | (i & l) | (h & l)}, 32'h0);
    chk({nm, "_break_before_make"}, {23'b0, (h & (pi | pl)) | (l & (pi | ph))}, 32'h0);
  endtask
  function automatic logic cmp_at(input int c, input logic [7:0] code, input int nb, input int s, input int t);
    int off, j;
    off = c + 1 - (s + 1 + t);
    if (off >= 0 && off % (t + 1) == 0 && off / (t + 1) < nb) return code[nb - 1 - off / (t + 1)];
    j = off < 0 ? 0 : (off + t) / (t + 1);
    return j < nb ? ~code[nb - 1 - j] : 1'b0;
  endfunction
  // Called at a negedge; START is sampled at the next edge and the task returns at the negedge in the DONE cycle.
  task automatic conv(input bit b, input logic [7:0] code, input bit cont, input int gap);
    int nb, s, t, len;
    exp_t e;
    nb = b ? 4 : 8;
    s = b ? 1 : 4;
    t = b ? 3 : 1;
    len = s + 1 + nb * (t + 1);
    e.code = code;
    e.gap = gap;
    if (b) q_b.push_back(e); else q_a.push_back(e);
    if (b) if_b.start = 1'b1; else if_a.start = 1'b1;
    @(negedge clk);
    if (b) if_b.start = cont; else if_a.start = cont;
    for (int c = 0; c < len; c++) begin
      if (b) if_b.cmp = cmp_at(c, code, nb, s, t); else if_a.cmp = cmp_at(c, code, nb, s, t);
      dchk_a = !b && c + 1 >= s + 1 && c + 1 <= len;
      @(negedge clk);
    end
    dchk_a = 1'b0;
  endtask
  task automatic abort_a();
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if_a.cmp = cmp_at(c, 8'h5A, 8, 4, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_switches", 32'({if_a.cri, if_a.crh, if_a.crl}), 32'h0);
    chk("abort_switches_b", 32'({if_a.crib, if_a.crhb, if_a.crlb}), 32'h7FFFFFF);
    chk("abort_busy", 32'(if_a.busy), 32'h0);
    chk("abort_done", 32'(if_a.done), 32'h0);
    chk("abort_dout", 32'(if_a.dout), 32'h0);
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_in_reset_busy", 32'(if_a.busy), 32'h0);
    chk("start_in_reset_cri", 32'(if_a.cri), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    if_a.start = 1'b0;
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    inv("a", if_a.cri, if_a.crib, if_a.crh, if_a.crhb, if_a.crl, if_a.crlb, pa_i, pa_h, pa_l);
    pa_i = if_a.cri;
    pa_h = if_a.crh;
    pa_l = if_a.crl;
    if (dchk_a) chk("a_dummy_on_l", 32'({if_a.cri[8], if_a.crh[8], if_a.crl[8]}), 32'h1);
    if (rst) begin
      busy_a = 0;
      samp_a = 0;
      dout_a = 8'h00;
    end
    if (if_a.cri == 9'h1FF) samp_a++;
    else if (samp_a != 0) begin
      samp_len_a = samp_a;
      samp_a = 0;
    end
    if (if_a.busy) busy_a++;
    if (if_a.done) begin
      chk("a_busy_in_done", 32'(if_a.busy), 32'h0);
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done dout=%0h required=no pulse", if_a.dout);
      end else begin
        ea = q_a.pop_front();
        chk("a_dout", 32'(if_a.dout), 32'(ea.code));
        chk("a_final_crh", 32'(if_a.crh), 32'({1'b0, ea.code}));
        chk("a_final_crl", 32'(if_a.crl), 32'({1'b1, ~ea.code}));
        chk("a_busy_len", 32'(busy_a), 32'd21);
        chk("a_sample_len", 32'(samp_len_a), 32'd4);
        if (ea.gap != 0) chk("a_done_period", 32'(cyc - last_a), 32'(ea.gap));
        dout_a = ea.code;
      end
      busy_a = 0;
      last_a = cyc;
    end else chk("a_dout_hold", 32'(if_a.dout), 32'(dout_a));
  end
  always @(posedge clk) begin
    #1;
    inv("b", {4'b0, if_b.cri}, {4'hF, if_b.crib}, {4'b0, if_b.crh}, {4'hF, if_b.crhb},
        {4'b0, if_b.crl}, {4'hF, if_b.crlb}, pb_i, pb_h, pb_l);
    pb_i = {4'b0, if_b.cri};
    pb_h = {4'b0, if_b.crh};
    pb_l = {4'b0, if_b.crl};
    if (rst) busy_b = 0;
    if (if_b.busy) busy_b++;
    if (if_b.done) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done dout=%0h required=no pulse", if_b.dout);
      end else begin
        eb = q_b.pop_front();
        chk("b_dout", 32'(if_b.dout), 32'(eb.code[3:0]));
        chk("b_final_crh", 32'(if_b.crh), 32'({1'b0, eb.code[3:0]}));
        chk("b_final_crl", 32'(if_b.crl), 32'({1'b1, ~eb.code[3:0]}));
        chk("b_busy_len", 32'(busy_b), 32'd18);
      end
      busy_b = 0;
    end
  end
  initial begin
    if_a.start = 1'b0;
    if_a.cmp = 1'b0;
    if_b.start = 1'b0;
    if_b.cmp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_switches", 32'({if_a.cri, if_a.crh, if_a.crl}), 32'h0);
    chk("rst_a_switches_b", 32'({if_a.crib, if_a.crhb, if_a.crlb}), 32'h7FFFFFF);
    chk("rst_a_busy", 32'(if_a.busy), 32'h0);
    chk("rst_a_done", 32'(if_a.done), 32'h0);
    chk("rst_a_dout", 32'(if_a.dout), 32'h0);
    chk("rst_b_switches_b", 32'({if_b.crib, if_b.crhb, if_b.crlb}), 32'h7FFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    conv(0, 8'hA5, 1'b0, 0);
    repeat (3) @(negedge clk);
    conv(0, 8'hFF, 1'b0, 0);
    conv(0, 8'h00, 1'b0, 0);
    conv(0, 8'h5A, 1'b0, 0);
    conv(0, 8'h3C, 1'b1, 0);
    conv(0, 8'hC3, 1'b1, 22);
    conv(0, 8'h81, 1'b0, 22);
    repeat (2) @(negedge clk);
    abort_a();
    conv(0, 8'h96, 1'b0, 0);
    for (int n = 0; n < 1000; n++) conv(0, 8'($urandom_range(0, 255)), 1'b0, 0);
    repeat (2) @(negedge clk);
    conv(1, 8'h0A, 1'b0, 0);
    conv(1, 8'h05, 1'b0, 0);
    conv(1, 8'h0F, 1'b0, 0);
    conv(1, 8'h00, 1'b0, 0);
    conv(1, 8'h09, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("a_pending", 32'(q_a.size()), 32'h0);
    chk("b_pending", 32'(q_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
